muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 164 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: HI/LO multiply/divide unit for a MIPS-style pipeline.
// It runs one multiply or divide at a time: a 32-step shift-add multiply
// or a 32-step restoring divide, then one sign-fix cycle that writes HI/LO.
// Optional build macro: MULDIV_FAST_MUL_EN. When it is defined, MULT/MULTU
// skip the iteration phase and form the product in the single FIX cycle.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    // Operation state
    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;     // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] r_mcand;   // multiplicand magnitude (mul) or divisor magnitude (div)
    logic [31:0] r_b;       // raw divisor, kept for the divide-by-zero result
    logic        r_is_mul;
    logic        r_sa;      // dividend/multiplicand negative (signed ops only)
    logic        r_sb;      // divisor/multiplier negative (signed ops only)
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Decode and operand magnitudes
    logic        w_op_valid;
    logic        w_start_ok;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;

    assign w_op_valid = (op[3:2] == 2'b10);
    assign w_start_ok = (r_state == S_IDLE) && start && w_op_valid;
    assign w_signed   = ~op[0];
    assign w_a_neg    = w_signed & a[31];
    assign w_b_neg    = w_signed & b[31];
    assign w_a_mag    = w_a_neg ? (32'd0 - a) : a;
    assign w_b_mag    = w_b_neg ? (32'd0 - b) : b;

    // One multiply step: add multiplicand into the high half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mcand} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // One restoring divide step: shift the next dividend bit into the
    // 33-bit partial remainder and subtract when it does not go negative.
    logic [32:0] w_rem_sh;
    logic [33:0] w_sub;
    logic [63:0] w_div_next;
    logic        w_unused_ok;

    assign w_rem_sh    = {r_acc[63:32], r_acc[31]};
    assign w_sub       = {1'b0, w_rem_sh} - {2'b00, r_mcand};
    assign w_div_next  = w_sub[33] ? {w_rem_sh[31:0], r_acc[30:0], 1'b0}
                                   : {w_sub[31:0],    r_acc[30:0], 1'b1};
    // Bit 32 of a successful difference is always zero (remainder < divisor).
    assign w_unused_ok = &{1'b0, w_sub[32]};

    // Result formation for the FIX cycle
    logic [63:0] w_prod_mag;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_div_zero;

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] w_fast_prod;
    assign w_fast_prod = {32'd0, r_mcand} * {32'd0, r_acc[31:0]};
    assign w_prod_mag  = w_fast_prod;
`else
    assign w_prod_mag  = r_acc;
`endif

    assign w_prod     = (r_sa ^ r_sb) ? (64'd0 - w_prod_mag) : w_prod_mag;
    assign w_quo      = (r_sa ^ r_sb) ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    // Remainder follows the dividend's sign; for b=0 this reproduces a exactly.
    assign w_rem      = r_sa ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    assign w_div_zero = (r_b == 32'd0);

    // Sequencer: accept work in IDLE, iterate in RUN, commit HI/LO in FIX
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_acc    <= 64'd0;
            r_mcand  <= 32'd0;
            r_b      <= 32'd0;
            r_is_mul <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_cnt    <= 6'd0;
                        r_is_mul <= op[1];
                        r_sa     <= w_a_neg;
                        r_sb     <= w_b_neg;
                        r_b      <= b;
                        if (op[1]) begin
                            r_mcand <= w_a_mag;
                            r_acc   <= {32'd0, w_b_mag};
`ifdef MULDIV_FAST_MUL_EN
                            r_state <= S_FIX;
`else
                            r_state <= S_RUN;
`endif
                        end else begin
                            r_mcand <= w_b_mag;
                            r_acc   <= {32'd0, w_a_mag};
                            r_state <= S_RUN;
                        end
                    end else begin
                        // Moves only land when no operation is being accepted
                        if (mthi) r_hi <= wdata;
                        if (mtlo) r_lo <= wdata;
                    end
                end
                S_RUN: begin
                    r_acc <= r_is_mul ? w_mul_next : w_div_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_is_mul) begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_div_zero ? 32'hFFFF_FFFF : w_quo;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_FIX);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a vector table of multiply/divide
// cases plus hand-written sequences for moves, ignored starts and reset.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;

    localparam logic [3:0] DIV = 4'b1000, DIVU = 4'b1001, MULT = 4'b1010, MULTU = 4'b1011;

    muldiv_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          mv;
        string       name;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat(input logic [3:0] o);
`ifdef MULDIV_FAST_MUL_EN
        if (o[1]) return 1;
`endif
        return 33;
    endfunction

    // Issue one operation and watch a fixed 40-cycle window.
    task automatic run_op(input vec_t v);
        logic [31:0] h0, l0;
        int dcyc, bcyc, ndone;
        bit hold_ok;
        @(negedge clk);
        h0 = hi; l0 = lo;
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        if (v.mv) begin mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEADBEEF; end
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
        dcyc = 0; bcyc = 0; ndone = 0; hold_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) bcyc++;
            if (done) begin
                ndone++;
                if (dcyc == 0) dcyc = k;
            end
            if ((dcyc == 0 || dcyc == k) && (hi !== h0 || lo !== l0)) hold_ok = 1'b0;
        end
        chk({v.name, "_hi"}, hi, v.hi);
        chk({v.name, "_lo"}, lo, v.lo);
        chk({v.name, "_done_cycle"}, dcyc, lat(v.op));
        chk({v.name, "_busy_cycles"}, bcyc, lat(v.op));
        chk({v.name, "_done_count"}, ndone, 1);
        chk({v.name, "_hilo_hold"}, {31'd0, hold_ok}, 32'd1);
    endtask

    initial begin
        int ndone, dcyc;
        vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max"};
        vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_neg3x7"};
        vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg7by2"};
        vecs[3]  = '{DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b0, "divu_by0"};
        vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_ovf"};
        vecs[5]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b1, "divu_start_wins"};
        vecs[6]  = '{MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, "mult_maxpos"};
        vecs[7]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, "div_7byneg2"};
        vecs[8]  = '{DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, "div_neg_by0"};
        vecs[9]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_minxmin"};
        vecs[10] = '{MULTU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 1'b0, "multu_carry"};
        vecs[11] = '{DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0, "divu_big"};
        vecs[12] = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, "mult_m1xm1"};

        // Reset state
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        #16 reset_n = 1'b1;

        // Moves in IDLE, then an unsupported op that must be ignored
        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5A5A5;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
        chk("mv_both_hi", hi, 32'hA5A5A5A5);
        chk("mv_both_lo", lo, 32'hA5A5A5A5);
        mthi = 1'b1; wdata = 32'h11112222;
        @(negedge clk); mthi = 1'b0;
        chk("mthi_only_hi", hi, 32'h11112222);
        chk("mthi_only_lo", lo, 32'hA5A5A5A5);
        start = 1'b1; op = 4'b0010;
        @(negedge clk); start = 1'b0; op = 4'd0;
        chk("badop_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("badop_busy2", {31'd0, busy}, 32'd0);
        chk("badop_hi", hi, 32'h11112222);
        chk("badop_lo", lo, 32'hA5A5A5A5);

        foreach (vecs[i]) run_op(vecs[i]);

        // Second start and mthi while busy must not disturb the divide
        @(negedge clk);
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        ndone = 0; dcyc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 5) begin
                start = 1'b1; op = MULTU; a = 32'd2; b = 32'd3; mthi = 1'b1; wdata = 32'h1234;
            end
            if (k == 6) begin start = 1'b0; mthi = 1'b0; end
            if (done) begin ndone++; if (dcyc == 0) dcyc = k; end
        end
        chk("busy_ign_lo", lo, 32'd14);
        chk("busy_ign_hi", hi, 32'd2);
        chk("busy_ign_done_count", ndone, 1);
        chk("busy_ign_done_cycle", dcyc, 33);

        // Reset mid-divide: outputs clear at once, no done, then a fresh multiply
        @(negedge clk);
        start = 1'b1; op = DIVU; a = 32'h1000; b = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        chk("midrst_hold_hi", hi, 32'd0);
        @(posedge clk); #1;
        run_op('{MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "post_rst_multu"});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
